elevator_motion_controller: RTL and testbench
=============================================

# elevator_motion_controller

Scheduling and motion state machine for a single elevator car. It consumes the decoded floor index and an at-floor qualifier from the floor position detection stage, latches hall/car call requests, and drives the motor and door outputs. Scheduling is collective (SCAN): the car keeps its direction while requests remain ahead of it, and reverses otherwise. A travel watchdog forces a latched fault if the car leaves a floor and never reaches the next one.

## Interface
- NUM_FLOORS, 10, number of floors; floor indices run 0..NUM_FLOORS-1
- FLOOR_WIDTH, 4, width of the floor index
- DOOR_OPEN_CYCLES, 8, number of cycles door_open stays high per stop (≥1)
- TRAVEL_TIMEOUT, 1000, maximum number of consecutive MOVE cycles with at_floor low before a fault (≥2)

- clk  input  1  single clock; all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- current_floor  input  FLOOR_WIDTH  floor index from the detector; valid only when at_floor=1
- at_floor  input  1  OR of all floor sensors; car is aligned with a floor
- call_req  input  NUM_FLOORS  one bit per floor; any-length pulse requests service
- motor_up  output  1  drive car upward
- motor_down  output  1  drive car downward
- door_open  output  1  door open command
- dir_up  output  1  current/last travel direction: 1=up, 0=down
- pending  output  NUM_FLOORS  latched outstanding requests
- busy  output  1  high whenever state≠IDLE
- fault  output  1  sticky watchdog fault

## Operation
- Qualified floor: valid_floor = at_floor & (current_floor < NUM_FLOORS). If current_floor is out of range, the block treats the car as between floors.
- Request masks, computed from pending:
  - above = any pending bit with index > current_floor
  - below = any pending bit with index < current_floor
  - here = pending[current_floor] & valid_floor
- Pending update each cycle: pending <= (pending | call_req) & ~clr.
  - clr is one-hot at current_floor on the edge that enters DOOR_OPEN, and also on every cycle spent in DOOR_OPEN. Otherwise clr is 0.
  - When a bit is being cleared on the same edge that call_req sets it, the clear wins.
- Registers and their reset values: state=IDLE, pending=0, dir_up=1, door timer=0, watchdog=0, fault=0.
- Outputs are decoded from the state register:
  - motor_up=(MOVE_UP)
  - motor_down=(MOVE_DOWN)
  - door_open=(DOOR_OPEN)
  - fault=(FAULT)
  - All outputs are 0 at reset except dir_up, which resets to 1.
- State transitions:
  - IDLE:
    - if here → DOOR_OPEN;
    - else if valid_floor and both above and below are set → continue in the dir_up direction;
    - else if above → MOVE_UP, dir_up=1;
    - else if below → MOVE_DOWN, dir_up=0;
    - else stay in IDLE.
    - If valid_floor=0 in IDLE, the block waits; it never moves blind.
  - MOVE_UP / MOVE_DOWN:
    - if valid_floor & pending[current_floor] → DOOR_OPEN;
    - else if valid_floor and the car is at the end floor (NUM_FLOORS-1 for up, 0 for down) → IDLE (limit guard);
    - else if watchdog reaches TRAVEL_TIMEOUT-1 with at_floor=0 → FAULT.
  - DOOR_OPEN: on entry the timer loads DOOR_OPEN_CYCLES-1 and then decrements once per cycle.
    - A call_req for the current floor during DOOR_OPEN reloads the timer and is not latched.
    - When the timer is 0 and no reload is occurring → IDLE.
  - FAULT: motors off and door closed. Only rst exits this state. pending continues to latch requests.
- Watchdog: counts only in MOVE states while at_floor=0. It clears whenever at_floor=1 or the state is not MOVE.

## Timing
- A call_req sampled at edge n appears in pending after edge n.
- The IDLE decision uses the registered pending value. For a request ahead of an idle car issued at edge n, motor_* rises after edge n+1 (2-cycle latency).
- Arrival: at the edge where valid_floor & pending[current_floor] is sampled in MOVE, all of the following happen together:
  - motor_* falls;
  - door_open rises;
  - the pending bit clears.
- door_open stays high exactly DOOR_OPEN_CYCLES cycles, plus any reloads. The following cycle is IDLE (door closed, motors off). The minimum gap between door close and motor start is 1 cycle.
- motor_up and motor_down are never high together. door_open is never high while either motor is high.
- rst asserted at any time, including mid-move or mid-door: after that edge all state is at its reset values. Requests pending before reset are lost.

## Test plan
- Reset, idle at floor 0, pulse call_req[3] for 1 cycle. Required response:
  - pending=0x008 the next cycle;
  - motor_up=1, dir_up=1 two cycles after the pulse;
  - when the bench presents current_floor=3 with at_floor=1, door_open=1 for 8 cycles and pending=0;
  - the block then returns to IDLE.
- Car at floor 5 moving up with requests at 7 and 2. Required: the car stops at 7, opens the door, then runs MOVE_DOWN with dir_up=0 and stops at 2. It passes floors 6, 4 and 3 without stopping.
- During DOOR_OPEN at floor 4, pulse call_req[4] on door cycle 6. Required: door_open stays high for 8 more cycles and pending[4] stays 0.
- Car moving up, at_floor held 0 for 1000 cycles. Required: fault=1 and motors 0. A later call_req is latched into pending but produces no motion. rst clears fault and pending.
- Idle at floor 2 with requests at 0 and 9 set in the same cycle, dir_up=1. Required: the car goes MOVE_UP first. current_floor=12 with at_floor=1 must never trigger a stop or a clear.

Source files
------------

// File: rtl/elevator_motion_controller.sv
// elevator_motion_controller
// ---------------------------------------------------------------------------
// Scheduling and motion FSM for a single elevator car. Latches hall/car
// calls into a pending mask, chooses a travel direction with collective
// (SCAN) scheduling, drives the motor and door commands and raises a sticky
// fault when the car leaves a floor and never reaches another one.
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous, active-high reset
//   current_floor floor index from the detector (meaningful only with at_floor)
//   at_floor      car aligned with some floor
//   call_req      one bit per floor, a pulse of any length requests service
//   motor_up      drive car upward
//   motor_down    drive car downward
//   door_open     door open command
//   dir_up        current/last travel direction (1 = up)
//   pending       latched outstanding requests
//   busy          FSM is not idle
//   fault         sticky travel-watchdog fault (cleared only by rst)
//   state_dbg     raw FSM state register for checkers
//
// Request interface: call_req has no handshake. A request bit is accepted on
// every rising edge it is high and is visible in pending after that edge,
// except for the floor the door is currently open at, where it only extends
// the door time.
// ---------------------------------------------------------------------------
module elevator_motion_controller #(
  parameter int NUM_FLOORS       = 10,
  parameter int FLOOR_WIDTH      = 4,
  parameter int DOOR_OPEN_CYCLES = 8,
  parameter int TRAVEL_TIMEOUT   = 1000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [FLOOR_WIDTH-1:0] current_floor,
  input  logic                   at_floor,
  input  logic [NUM_FLOORS-1:0]  call_req,
  output logic                   motor_up,
  output logic                   motor_down,
  output logic                   door_open,
  output logic                   dir_up,
  output logic [NUM_FLOORS-1:0]  pending,
  output logic                   busy,
  output logic                   fault,
  output logic [2:0]             state_dbg
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_MOVE_UP   = 3'd1,
    ST_MOVE_DOWN = 3'd2,
    ST_DOOR_OPEN = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;

  localparam int TIMER_W = (DOOR_OPEN_CYCLES > 1) ? $clog2(DOOR_OPEN_CYCLES) : 1;
  localparam int WDOG_W  = $clog2(TRAVEL_TIMEOUT);

  localparam logic [FLOOR_WIDTH-1:0] LAST_FLOOR = FLOOR_WIDTH'(NUM_FLOORS - 1);
  localparam logic [TIMER_W-1:0]     DOOR_LOAD  = TIMER_W'(DOOR_OPEN_CYCLES - 1);
  localparam logic [WDOG_W-1:0]      WDOG_LAST  = WDOG_W'(TRAVEL_TIMEOUT - 1);

  state_t                  state, state_n;
  logic                    dir_n;
  logic [NUM_FLOORS-1:0]   pending_n;
  logic [TIMER_W-1:0]      door_timer, door_timer_n;
  logic [WDOG_W-1:0]       wdog, wdog_n;

  logic                    valid_floor;
  logic [NUM_FLOORS-1:0]   floor_onehot;
  logic                    above, below;
  logic                    pending_here;
  logic                    call_here;
  logic                    clr_en;

  // An out-of-range index is treated exactly like being between floors.
  assign valid_floor = at_floor && (current_floor <= LAST_FLOOR);

  // floor_onehot is all-zero for an out-of-range index, so neither a stop
  // nor a clear can be aimed at a non-existent floor.
  always_comb begin
    floor_onehot = '0;
    above        = 1'b0;
    below        = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      floor_onehot[i] = (FLOOR_WIDTH'(i) == current_floor);
      if (pending[i] && (FLOOR_WIDTH'(i) > current_floor)) above = 1'b1;
      if (pending[i] && (FLOOR_WIDTH'(i) < current_floor)) below = 1'b1;
    end
  end

  assign pending_here = |(pending & floor_onehot);
  assign call_here    = |(call_req & floor_onehot);

  always_comb begin
    state_n      = state;
    dir_n        = dir_up;
    door_timer_n = door_timer;
    wdog_n       = '0;
    clr_en       = 1'b0;

    unique case (state)
      ST_IDLE: begin
        // Never start moving without a trustworthy floor reading.
        if (valid_floor) begin
          if (pending_here) begin
            state_n      = ST_DOOR_OPEN;
            door_timer_n = DOOR_LOAD;
            clr_en       = 1'b1;
          end else if (above && below) begin
            state_n = dir_up ? ST_MOVE_UP : ST_MOVE_DOWN;
          end else if (above) begin
            state_n = ST_MOVE_UP;
            dir_n   = 1'b1;
          end else if (below) begin
            state_n = ST_MOVE_DOWN;
            dir_n   = 1'b0;
          end
        end
      end

      ST_MOVE_UP, ST_MOVE_DOWN: begin
        wdog_n = at_floor ? '0 : wdog + 1'b1;
        if (valid_floor && pending_here) begin
          state_n      = ST_DOOR_OPEN;
          door_timer_n = DOOR_LOAD;
          clr_en       = 1'b1;
          wdog_n       = '0;
        end else if (valid_floor &&
                     (current_floor == ((state == ST_MOVE_UP) ? LAST_FLOOR : '0))) begin
          // Limit guard: nothing left to serve past the end floor.
          state_n = ST_IDLE;
          wdog_n  = '0;
        end else if (!at_floor && (wdog == WDOG_LAST)) begin
          state_n = ST_FAULT;
          wdog_n  = '0;
        end
      end

      ST_DOOR_OPEN: begin
        // A call for this floor is absorbed: it restarts the door time and
        // the clear below keeps it out of pending.
        clr_en = 1'b1;
        if (call_here) begin
          door_timer_n = DOOR_LOAD;
        end else if (door_timer == '0) begin
          state_n = ST_IDLE;
        end else begin
          door_timer_n = door_timer - 1'b1;
        end
      end

      ST_FAULT: begin
        state_n = ST_FAULT;
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase

    // Clear wins over a same-edge set of the same bit.
    pending_n = (pending | call_req) & ~(clr_en ? floor_onehot : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      pending    <= '0;
      dir_up     <= 1'b1;
      door_timer <= '0;
      wdog       <= '0;
    end else begin
      state      <= state_n;
      pending    <= pending_n;
      dir_up     <= dir_n;
      door_timer <= door_timer_n;
      wdog       <= wdog_n;
    end
  end

  assign motor_up   = (state == ST_MOVE_UP);
  assign motor_down = (state == ST_MOVE_DOWN);
  assign door_open  = (state == ST_DOOR_OPEN);
  assign fault      = (state == ST_FAULT);
  assign busy       = (state != ST_IDLE);
  assign state_dbg  = state;

endmodule

// File: tb/tb_elevator_motion_controller.sv
// Bench for elevator_motion_controller: directed scenarios with literal
// expectations, then a randomized run where a small car plant moves the car
// according to the motor commands. A behavioural model tracks pending calls,
// motion, door time and travel time; every cycle the outputs are compared.
module tb_elevator_motion_controller;

  localparam int NF  = 10;
  localparam int FW  = 4;
  localparam int DOC = 8;
  localparam int TT  = 1000;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic [FW-1:0] current_floor;
  logic          at_floor;
  logic [NF-1:0] call_req;
  logic          motor_up, motor_down, door_open, dir_up, busy, fault;
  logic [NF-1:0] pending;
  logic [2:0]    state_dbg;

  always #5 clk = ~clk;

  elevator_motion_controller #(
    .NUM_FLOORS(NF), .FLOOR_WIDTH(FW),
    .DOOR_OPEN_CYCLES(DOC), .TRAVEL_TIMEOUT(TT)
  ) dut (
    .clk(clk), .rst(rst),
    .current_floor(current_floor), .at_floor(at_floor), .call_req(call_req),
    .motor_up(motor_up), .motor_down(motor_down), .door_open(door_open),
    .dir_up(dir_up), .pending(pending), .busy(busy), .fault(fault),
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Car described as: moving up / moving down / door open for m_door more
  // cycles / faulted / otherwise parked. m_trav counts consecutive cycles of
  // travel spent away from any floor.
  bit [NF-1:0] m_pend;
  bit [NF-1:0] m_nxt;
  bit          m_up, m_down, m_fault, m_dir;
  int          m_door, m_trav;
  int          m_cf;
  bit          m_vf, m_above, m_below;

  always @(posedge clk) begin
    m_cf  = int'(current_floor);
    m_vf  = at_floor && (m_cf < NF);
    m_nxt = m_pend | call_req;
    if (rst) begin
      m_pend = '0; m_up = 0; m_down = 0; m_fault = 0; m_dir = 1;
      m_door = 0;  m_trav = 0;
    end else if (m_fault) begin
      m_pend = m_nxt;
    end else if (m_door > 0) begin
      if (m_cf < NF) begin
        m_nxt[m_cf] = 1'b0;
        m_door = call_req[m_cf] ? DOC : m_door - 1;
      end else begin
        m_door = m_door - 1;
      end
      m_pend = m_nxt;
    end else if (m_up || m_down) begin
      if (m_vf && m_pend[m_cf]) begin
        m_up = 0; m_down = 0; m_door = DOC; m_trav = 0;
        m_nxt[m_cf] = 1'b0;
      end else if (m_vf && (m_cf == (m_up ? NF - 1 : 0))) begin
        m_up = 0; m_down = 0; m_trav = 0;
      end else if (!at_floor && (m_trav + 1 == TT)) begin
        m_up = 0; m_down = 0; m_fault = 1; m_trav = 0;
      end else begin
        m_trav = at_floor ? 0 : m_trav + 1;
      end
      m_pend = m_nxt;
    end else begin
      if (m_vf) begin
        m_above = 0; m_below = 0;
        for (int i = 0; i < NF; i++) begin
          if (m_pend[i] && i > m_cf) m_above = 1;
          if (m_pend[i] && i < m_cf) m_below = 1;
        end
        if (m_pend[m_cf]) begin
          m_door = DOC;
          m_nxt[m_cf] = 1'b0;
        end else if (m_above && m_below) begin
          if (m_dir) m_up = 1; else m_down = 1;
        end else if (m_above) begin
          m_up = 1; m_dir = 1;
        end else if (m_below) begin
          m_down = 1; m_dir = 0;
        end
      end
      m_pend = m_nxt;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("motor_up",   motor_up,   m_up);
      chk("motor_down", motor_down, m_down);
      chk("door_open",  door_open,  m_door > 0);
      chk("dir_up",     dir_up,     m_dir);
      chk("pending",    pending,    m_pend);
      chk("fault",      fault,      m_fault);
      chk("busy",       busy,       m_up | m_down | (m_door > 0) | m_fault);
      chk("interlock",  (motor_up & motor_down) | (door_open & (motor_up | motor_down)), 0);
    end
  end

  // ---------------- driver tasks ----------------
  task step();
    @(posedge clk);
    #1;
  endtask

  // Leave the current floor, travel two cycles between floors, arrive at f.
  task automatic drive_floor(input int f);
    at_floor = 1'b0;
    step();
    step();
    current_floor = f[FW-1:0];
    at_floor = 1'b1;
    step();
  endtask

  task automatic check_door_run(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      step();
      chk(name, door_open, 1);
    end
  endtask

  int pos;
  int idx;

  initial begin
    rst = 1'b1; current_floor = '0; at_floor = 1'b1; call_req = '0;
    step();
    step();
    rst = 1'b0;
    chk_en = 1'b1;
    step();
    chk("reset_pending", pending, 0);
    chk("reset_dir_up", dir_up, 1);
    chk("reset_busy", busy, 0);

    // ---- 1: single request to floor 3 from floor 0 ----
    call_req = 10'h008;
    step();
    call_req = '0;
    chk("t1_pending_latch", pending, 10'h008);
    chk("t1_no_motor_yet", motor_up, 0);
    step();
    chk("t1_motor_up", motor_up, 1);
    chk("t1_dir_up", dir_up, 1);
    drive_floor(1);
    chk("t1_pass1", motor_up, 1);
    drive_floor(2);
    chk("t1_pass2", motor_up, 1);
    drive_floor(3);
    chk("t1_arrive_door", door_open, 1);
    chk("t1_arrive_motor", motor_up, 0);
    chk("t1_arrive_clear", pending, 0);
    check_door_run("t1_door_hold", DOC - 1);
    step();
    chk("t1_door_closed", door_open, 0);
    chk("t1_idle", busy, 0);

    // ---- 2: requests at 7 and 2, SCAN up first then down ----
    call_req = 10'h084;
    step();
    call_req = '0;
    chk("t2_pending", pending, 10'h084);
    step();
    chk("t2_up_first", motor_up, 1);
    for (int f = 4; f <= 6; f++) begin
      drive_floor(f);
      chk("t2_pass_up_door", door_open, 0);
      chk("t2_pass_up_motor", motor_up, 1);
    end
    drive_floor(7);
    chk("t2_stop7", door_open, 1);
    chk("t2_clear7", pending, 10'h004);
    check_door_run("t2_door7", DOC - 1);
    step();
    chk("t2_gap", busy, 0);
    step();
    chk("t2_down", motor_down, 1);
    chk("t2_dir_down", dir_up, 0);
    for (int f = 6; f >= 3; f--) begin
      drive_floor(f);
      chk("t2_pass_dn_door", door_open, 0);
      chk("t2_pass_dn_motor", motor_down, 1);
    end
    drive_floor(2);
    chk("t2_stop2", door_open, 1);
    chk("t2_clear2", pending, 0);
    check_door_run("t2_door2", DOC - 1);
    step();
    chk("t2_closed", door_open, 0);

    // ---- 3: door reload at floor 4 on door cycle 6 ----
    call_req = 10'h010;
    step();
    call_req = '0;
    step();
    chk("t3_up", motor_up, 1);
    drive_floor(3);
    drive_floor(4);
    chk("t3_door", door_open, 1);
    check_door_run("t3_door_pre", 5);
    call_req = 10'h010;
    step();
    call_req = '0;
    chk("t3_reload_door", door_open, 1);
    chk("t3_not_latched", pending, 0);
    check_door_run("t3_door_post", DOC - 1);
    step();
    chk("t3_closed", door_open, 0);

    // ---- 4: travel watchdog ----
    call_req = 10'h100;
    step();
    call_req = '0;
    step();
    chk("t4_up", motor_up, 1);
    at_floor = 1'b0;
    repeat (TT - 1) step();
    chk("t4_no_fault_yet", fault, 0);
    step();
    chk("t4_fault", fault, 1);
    chk("t4_motor_up_off", motor_up, 0);
    chk("t4_motor_dn_off", motor_down, 0);
    call_req = 10'h002;
    current_floor = 4'd1;
    at_floor = 1'b1;
    step();
    call_req = '0;
    chk("t4_latched", pending, 10'h102);
    repeat (5) step();
    chk("t4_no_motion", motor_up | motor_down, 0);
    chk("t4_still_fault", fault, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t4_rst_fault", fault, 0);
    chk("t4_rst_pending", pending, 0);

    // ---- 5: both directions pending from floor 2, out-of-range floor ----
    current_floor = 4'd2;
    at_floor = 1'b1;
    step();
    call_req = 10'h201;
    step();
    call_req = '0;
    chk("t5_pending", pending, 10'h201);
    step();
    chk("t5_up_first", motor_up, 1);
    chk("t5_dir", dir_up, 1);
    at_floor = 1'b0;
    step();
    current_floor = 4'd12;
    at_floor = 1'b1;
    step();
    chk("t5_bad_floor_door", door_open, 0);
    chk("t5_bad_floor_motor", motor_up, 1);
    chk("t5_bad_floor_pend", pending, 10'h201);
    for (int f = 3; f <= 8; f++) drive_floor(f);
    chk("t5_still_up", motor_up, 1);
    drive_floor(9);
    chk("t5_stop9", door_open, 1);
    chk("t5_clear9", pending, 10'h001);

    // ---- 6: randomized run with a car plant ----
    rst = 1'b1;
    pos = 4 * $urandom_range(0, NF - 1);
    current_floor = FW'(pos / 4);
    at_floor = 1'b1;
    call_req = '0;
    step();
    rst = 1'b0;
    repeat (20000) begin
      if (motor_up && pos < 4 * (NF - 1)) pos++;
      else if (motor_down && pos > 0) pos--;
      if (pos % 4 == 0) begin
        current_floor = FW'(pos / 4);
        at_floor = 1'b1;
      end else if ($urandom_range(0, 7) == 0) begin
        current_floor = FW'($urandom_range(12, 15));
        at_floor = 1'b1;
      end else begin
        current_floor = FW'(pos / 4);
        at_floor = 1'b0;
      end
      call_req = '0;
      if ($urandom_range(0, 5) == 0) begin
        idx = $urandom_range(0, NF - 1);
        call_req[idx] = 1'b1;
      end
      rst = ($urandom_range(0, 2999) == 0);
      step();
    end
    rst = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
